// File: rtl/sevenseg_scan_driver_if.sv
// Purpose: bundles the display-value inputs and the multiplexed pin outputs of the scan driver.
// Latency: none, wiring only.
// Backpressure: none; the display side is free-running and never stalls the producer.
interface sevenseg_scan_driver_if;
  // Producer (processor wrapper) side
  logic [31:0] HEX_IN;
  logic [7:0]  DP_MASK;
  logic        BLANK_LZ;
  logic        ENABLE;
  // Display pin side
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        FRAME_TICK;

  modport master (
    output HEX_IN, DP_MASK, BLANK_LZ, ENABLE,
    input  AN, SEG, DP, FRAME_TICK
  );

  modport slave (
    input  HEX_IN, DP_MASK, BLANK_LZ, ENABLE,
    output AN, SEG, DP, FRAME_TICK
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Purpose: time-multiplexes a 32-bit value onto an 8-digit common-anode display as hex, tear-free.
// Latency: AN/SEG/DP follow divider, index, shadow and ENABLE by one cycle; FRAME_TICK one cycle after capture.
// Backpressure: none; inputs are sampled only at frame capture edges and may change at any time.
module sevenseg_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  sevenseg_scan_driver_if.slave bus
);

  // Divider width covers 0..DIGIT_CYCLES-1.
  localparam int DW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] DIV_GAP  = DW'(GAP_CYCLES);

  // UNPRIMED only lasts until the first edge after reset, which forces a capture.
  typedef enum logic {
    ST_UNPRIMED = 1'b0,
    ST_RUN      = 1'b1
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   hex_q, hex_d;
  logic [7:0]    dpm_q, dpm_d;
  logic          blz_q, blz_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic          wrap;
  logic          capture;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          blanked;
  logic          lit;

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Slot timing: divider wraps every DIGIT_CYCLES, index steps on each wrap.
  // Capture happens on the priming edge and on the last edge of digit 7,
  // which is the same edge at which the index returns to 0.
  always_comb begin
    wrap    = (div_q == DIV_LAST);
    div_d   = wrap ? '0 : div_q + DW'(1);
    idx_d   = wrap ? idx_q + 3'd1 : idx_q;
    capture = (state_q == ST_UNPRIMED) || (wrap && (idx_q == 3'd7));
    tick_d  = capture;
  end

  // Shadow copy of the display value, refreshed only at frame boundaries.
  always_comb begin
    hex_d = capture ? bus.HEX_IN   : hex_q;
    dpm_d = capture ? bus.DP_MASK  : dpm_q;
    blz_d = capture ? bus.BLANK_LZ : blz_q;
  end

  // Pin values for the current slot, taken from the shadow only.
  // A digit is a leading zero when it and every digit to its left are zero;
  // digit 0 always shows so that a zero value still reads "0".
  always_comb begin
    nib     = hex_q[{idx_q, 2'b00} +: 4];
    upper   = hex_q >> {idx_q, 2'b00};
    blanked = blz_q && (idx_q != 3'd0) && (upper == 32'd0);
    lit     = bus.ENABLE && (div_q >= DIV_GAP) && !blanked;
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (lit) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = decode(nib);
      dp_d  = ~dpm_q[idx_q];
    end
  end

  // State, divider, shadow and registered pin outputs; reset darkens the pins at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_UNPRIMED;
      div_q   <= '0;
      idx_q   <= 3'd0;
      hex_q   <= 32'd0;
      dpm_q   <= 8'd0;
      blz_q   <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= ST_RUN;
      div_q   <= div_d;
      idx_q   <= idx_d;
      hex_q   <= hex_d;
      dpm_q   <= dpm_d;
      blz_q   <= blz_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.DP         = dp_q;
  assign bus.FRAME_TICK = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Purpose: scoreboard bench for sevenseg_scan_driver with DIGIT_CYCLES=8, GAP_CYCLES=2.
// Latency: expected pin values are tagged with the cycle they must appear in.
// Backpressure: none; the monitor consumes one tagged entry per observed cycle.
module tb_sevenseg_scan_driver;
  localparam int DC = 8;
  localparam int GC = 2;
  localparam int FRAME = 8 * DC;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  sevenseg_scan_driver_if bus();

  sevenseg_scan_driver #(
    .DIGIT_CYCLES(DC),
    .GAP_CYCLES  (GC)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Cycle n = state of the pins after the n-th edge since reset release.
  int cyc = 0;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    string      nm;
  } exp_t;

  typedef logic [6:0] segs_t [8];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  task automatic push_dark(input int c, input string nm);
    exp_t e;
    e.cyc = c; e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0; e.nm = nm;
    sb.push_back(e);
  endtask

  // One frame (or its first len cycles) starting at slot 0 phase 0.
  // segs: hand-decoded segment value per digit; litm: digits not blanked;
  // cycles off_lo..off_hi of the frame are dark because ENABLE is low.
  task automatic push_frame(input int start, input int len, input segs_t segs,
                            input logic [7:0] litm, input logic [7:0] dpm,
                            input bit first_tick, input int off_lo, input int off_hi,
                            input string nm);
    exp_t e;
    int   k;
    int   p;
    bit   lit;
    for (int i = 0; i < len; i++) begin
      k     = i / DC;
      p     = i % DC;
      lit   = (p >= GC) && litm[k] && !((i >= off_lo) && (i <= off_hi));
      e.cyc = start + i;
      e.an  = lit ? ~(8'd1 << k) : 8'hFF;
      e.seg = lit ? segs[k] : 7'h7F;
      e.dp  = lit ? ~dpm[k] : 1'b1;
      e.tick = (i == FRAME - 1) || (first_tick && (i == 0));
      e.nm  = nm;
      sb.push_back(e);
    end
  endtask

  task automatic at_cyc(input int n);
    do @(negedge CLK); while (cyc != n);
  endtask

  // Monitor: compare every tagged entry in the cycle it belongs to.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: entry for cyc %0d not observed, now at cyc %0d", e.nm, e.cyc, cyc);
        end else if (bus.AN !== e.an || bus.SEG !== e.seg || bus.DP !== e.dp ||
                     bus.FRAME_TICK !== e.tick) begin
          errors++;
          $display("FAIL %s cyc=%0d: got AN=%h SEG=%h DP=%b TICK=%b, want AN=%h SEG=%h DP=%b TICK=%b",
                   e.nm, cyc, bus.AN, bus.SEG, bus.DP, bus.FRAME_TICK, e.an, e.seg, e.dp, e.tick);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Stimulus
  initial begin
    segs_t s;
    bus.HEX_IN   = 32'h12345678;
    bus.DP_MASK  = 8'h00;
    bus.BLANK_LZ = 1'b0;
    bus.ENABLE   = 1'b1;
    #1 RESET = 1'b1;
    push_dark(0, "reset");

    // Basic scan of 12345678: digit0='8' .. digit7='1'
    s = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    push_frame(1, FRAME, s, 8'hFF, 8'h00, 1'b1, 1, 0, "scan");
    // Leading-zero blanking of 000000A0: digit1='A', digit0='0'
    s = '{7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    push_frame(1 + FRAME, FRAME, s, 8'h03, 8'h00, 1'b0, 1, 0, "lz_a0");
    // Zero with blanking: only digit 0
    s = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    push_frame(1 + 2*FRAME, FRAME, s, 8'h01, 8'h00, 1'b0, 1, 0, "lz_zero");
    // Tear-free: whole frame still 11111111 despite mid-frame change
    s = '{7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};
    push_frame(1 + 3*FRAME, FRAME, s, 8'hFF, 8'h00, 1'b0, 1, 0, "tear_old");
    // Next frame 22222222 with decimal points on digits 7 and 0
    s = '{7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24};
    push_frame(1 + 4*FRAME, FRAME, s, 8'hFF, 8'h81, 1'b0, 1, 0, "tear_new_dp");
    // Enable dropped in digit 2, restored in digit 5
    s = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    push_frame(1 + 5*FRAME, FRAME, s, 8'hFF, 8'h00, 1'b0, 20, 43, "enable");
    push_frame(1 + 6*FRAME, 10, s, 8'hFF, 8'h00, 1'b0, 1, 0, "pre_reset");

    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    at_cyc(FRAME - 1);            // changes land just before the capture edge
    bus.HEX_IN   = 32'h000000A0;
    bus.BLANK_LZ = 1'b1;
    at_cyc(100);
    bus.HEX_IN   = 32'h00000000;
    at_cyc(150);
    bus.HEX_IN   = 32'h11111111;
    bus.BLANK_LZ = 1'b0;
    at_cyc(3*FRAME + 28);         // inside digit 3 of the 11111111 frame
    bus.HEX_IN   = 32'h22222222;
    bus.DP_MASK  = 8'h81;
    at_cyc(290);
    bus.HEX_IN   = 32'h12345678;
    bus.DP_MASK  = 8'h00;
    at_cyc(5*FRAME + 20);         // digit 2, phase 3
    bus.ENABLE   = 1'b0;
    at_cyc(5*FRAME + 44);         // digit 5, phase 3
    bus.ENABLE   = 1'b1;

    // Reset in the middle of digit 1, between clock edges
    at_cyc(6*FRAME + 10);
    @(posedge CLK);
    #2 RESET = 1'b1;
    push_dark(0, "reset_mid");
    bus.HEX_IN = 32'h9ABCDEF0;
    s = '{7'h40, 7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10};
    push_frame(1, FRAME, s, 8'hFF, 8'h00, 1'b1, 1, 0, "restart");
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    at_cyc(FRAME + 2);
    done = 1'b1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
